// File: rtl/gshare_bht.sv
// gshare_bht: branch history table with n-bit saturating counters.
// It gives a combinational taken/not-taken prediction in IF and is trained from EX.
// After every reset it clears the table by sweeping one entry per cycle.
//
// Build option BHT_GSHARE_EN:
//   - Defined: the table index is the PC bits XOR a speculative global history
//     register (GHR). The GHR is checkpointed through ghr_IF/ghr_EX and restored
//     on a mispredict.
//   - Undefined: there is no GHR and the index is the PC bits alone, which makes
//     this a per-PC bimodal table. ghr_IF reads 0, and ghr_EX, stall_IF and
//     mispredict_EX are ignored.
//
// Sequencer states:
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_INIT | sweeping the table to weakly-taken; predictions/training off
//   ST_RUN  | normal operation; only reset leaves this state
module gshare_bht #(
    parameter int SET_ADDR_LEN = 12,
    parameter int CNT_WIDTH    = 2,
    parameter int GHR_LEN      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               ready,
    input  logic               stall_IF,
    input  logic [31:0]        PC_IF,
    input  logic               isHit_BTB,
    output logic               isTakenBr_Bht,
    output logic [GHR_LEN-1:0] ghr_IF,
    input  logic               wr_req,
    input  logic [31:0]        PC_EX,
    input  logic               isTakenBr_Ex,
    input  logic [GHR_LEN-1:0] ghr_EX,
    input  logic               mispredict_EX
);

    localparam int DEPTH = 1 << SET_ADDR_LEN;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_MIN  = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_WEAK = {1'b1, {(CNT_WIDTH-1){1'b0}}};

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [SET_ADDR_LEN-1:0] init_idx_q, init_idx_d;
    logic                    init_we;

    logic [CNT_WIDTH-1:0]    table_q [DEPTH];

    logic [SET_ADDR_LEN-1:0] hist_if, hist_ex;
    logic [SET_ADDR_LEN-1:0] idx_if, idx_ex;
    logic [CNT_WIDTH-1:0]    cnt_ex, cnt_trained;

    logic                    tbl_we;
    logic [SET_ADDR_LEN-1:0] tbl_waddr;
    logic [CNT_WIDTH-1:0]    tbl_wdata;

    // Only the index field of each PC is used; the remaining bits are sunk here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{PC_IF, PC_EX};

    // ------------------------------------------------------------------
    // Init sequencer
    // ------------------------------------------------------------------

    // State register and sweep pointer. Reset restarts the sweep at entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // Next state: advance one entry per cycle and leave INIT on the last entry.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        case (state_q)
            ST_INIT: begin
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == SET_ADDR_LEN'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Sequencer outputs. ready goes high on the same edge that writes the last entry.
    always_comb begin
        ready   = 1'b0;
        init_we = 1'b0;
        case (state_q)
            ST_INIT: init_we = 1'b1;
            ST_RUN:  ready   = 1'b1;
            default: init_we = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Global history
    // ------------------------------------------------------------------
`ifdef BHT_GSHARE_EN
    logic [GHR_LEN-1:0] ghr_q, ghr_d;
    logic [GHR_LEN-1:0] ghr_shift, ghr_restore;

    if (GHR_LEN == 1) begin : g_ghr_one
        assign ghr_shift   = isTakenBr_Bht;
        assign ghr_restore = isTakenBr_Ex;
        logic unused_ghr_ex;
        assign unused_ghr_ex = ^ghr_EX;
    end else begin : g_ghr_multi
        assign ghr_shift   = {ghr_q[GHR_LEN-2:0], isTakenBr_Bht};
        assign ghr_restore = {ghr_EX[GHR_LEN-2:0], isTakenBr_Ex};
    end

    // GHR update: restore on a mispredict wins over the speculative fetch shift.
    // Both are held off until the sweep is done.
    always_comb begin
        ghr_d = ghr_q;
        if (ready) begin
            if (mispredict_EX) begin
                ghr_d = ghr_restore;
            end else if (isHit_BTB && !stall_IF) begin
                ghr_d = ghr_shift;
            end
        end
    end

    // GHR register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign ghr_IF  = ghr_q;
    assign hist_if = SET_ADDR_LEN'(ghr_q);
    assign hist_ex = SET_ADDR_LEN'(ghr_EX);
`else
    // Bimodal build: no history, so these inputs only feed an unused sink.
    logic unused_ghr_inputs;
    assign unused_ghr_inputs = ^{ghr_EX, stall_IF, mispredict_EX};

    assign ghr_IF  = '0;
    assign hist_if = '0;
    assign hist_ex = '0;
`endif

    assign idx_if = PC_IF[SET_ADDR_LEN+1:2] ^ hist_if;
    assign idx_ex = PC_EX[SET_ADDR_LEN+1:2] ^ hist_ex;

    // ------------------------------------------------------------------
    // Counter table
    // ------------------------------------------------------------------

    assign isTakenBr_Bht = ready && isHit_BTB && table_q[idx_if][CNT_WIDTH-1];

    assign cnt_ex = table_q[idx_ex];

    // Saturating training step for the resolved branch.
    always_comb begin
        cnt_trained = cnt_ex;
        if (isTakenBr_Ex) begin
            if (cnt_ex != CNT_MAX) begin
                cnt_trained = cnt_ex + 1'b1;
            end
        end else begin
            if (cnt_ex != CNT_MIN) begin
                cnt_trained = cnt_ex - 1'b1;
            end
        end
    end

    // Single write port. The init sweep owns it until ready; after that, EX training owns it.
    always_comb begin
        tbl_we    = 1'b0;
        tbl_waddr = init_idx_q;
        tbl_wdata = CNT_WEAK;
        if (init_we) begin
            tbl_we    = 1'b1;
            tbl_waddr = init_idx_q;
            tbl_wdata = CNT_WEAK;
        end else if (wr_req && ready) begin
            tbl_we    = 1'b1;
            tbl_waddr = idx_ex;
            tbl_wdata = cnt_trained;
        end
    end

    // Table storage. It has no reset because the sweep clears it. The read port is
    // asynchronous, so a read in the same cycle as a write returns the old value.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            table_q[tbl_waddr] <= tbl_wdata;
        end
    end

endmodule

// File: tb/tb_gshare_bht.sv
// Directed testbench for gshare_bht (SET_ADDR_LEN=8, CNT_WIDTH=2, GHR_LEN=8).
// Expected GHR values depend on whether BHT_GSHARE_EN is defined for the build.
module tb_gshare_bht;

    localparam int SAL = 8;
    localparam int CW  = 2;
    localparam int GL  = 8;
`ifdef BHT_GSHARE_EN
    localparam bit GS = 1'b1;
`else
    localparam bit GS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          ready;
    logic          stall_IF = 1'b1;
    logic [31:0]   PC_IF = 32'h0;
    logic          isHit_BTB = 1'b0;
    logic          isTakenBr_Bht;
    logic [GL-1:0] ghr_IF;
    logic          wr_req = 1'b0;
    logic [31:0]   PC_EX = 32'h0;
    logic          isTakenBr_Ex = 1'b0;
    logic [GL-1:0] ghr_EX = '0;
    logic          mispredict_EX = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    gshare_bht #(
        .SET_ADDR_LEN(SAL),
        .CNT_WIDTH   (CW),
        .GHR_LEN     (GL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ready        (ready),
        .stall_IF     (stall_IF),
        .PC_IF        (PC_IF),
        .isHit_BTB    (isHit_BTB),
        .isTakenBr_Bht(isTakenBr_Bht),
        .ghr_IF       (ghr_IF),
        .wr_req       (wr_req),
        .PC_EX        (PC_EX),
        .isTakenBr_Ex (isTakenBr_Ex),
        .ghr_EX       (ghr_EX),
        .mispredict_EX(mispredict_EX)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One training cycle on pc with ghr_EX = 0 and no mispredict.
    task automatic train(input logic [31:0] pc, input logic taken);
        PC_EX        = pc;
        isTakenBr_Ex = taken;
        ghr_EX       = '0;
        wr_req       = 1'b1;
        tick();
        wr_req       = 1'b0;
    endtask

    // Rst_n was released just after an edge; count 2^SAL edges until ready.
    task automatic run_sweep(input string tag);
        for (int i = 1; i <= (1 << SAL); i++) begin
            tick();
            if (i == 128) begin
                chk({tag, "_pred_off"}, isTakenBr_Bht, 0);
                chk({tag, "_ghr_held"}, ghr_IF, 0);
            end
            if (i == (1 << SAL) - 1) chk({tag, "_ready_lo"}, ready, 0);
            if (i == (1 << SAL))     chk({tag, "_ready_hi"}, ready, 1);
        end
    endtask

    initial begin
        int taken_cnt;

        // ---------------- reset values ----------------
        #1 rst_n = 1'b0;
        isHit_BTB = 1'b1;
        PC_IF     = 32'h40;
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_ghr", ghr_IF, 0);
        chk("rst_pred", isTakenBr_Bht, 0);
        tick();
        tick();

        // ---------------- init sweep, with traffic that must be ignored ----------------
        rst_n         = 1'b1;
        stall_IF      = 1'b0;
        wr_req        = 1'b1;
        PC_EX         = 32'h40;
        isTakenBr_Ex  = 1'b1;
        mispredict_EX = 1'b1;
        ghr_EX        = 8'hFF;
        run_sweep("init");
        wr_req        = 1'b0;
        mispredict_EX = 1'b0;
        ghr_EX        = '0;
        stall_IF      = 1'b1;
        chk("init_ghr_zero", ghr_IF, 0);

        // Every entry reads weakly taken (GHR is 0, stall holds it).
        taken_cnt = 0;
        for (int i = 0; i < (1 << SAL); i++) begin
            PC_IF = 32'(i) << 2;
            #1;
            if (isTakenBr_Bht === 1'b1) taken_cnt++;
        end
        chk("all_weak_taken", taken_cnt, 1 << SAL);
        PC_IF     = 32'h40;
        isHit_BTB = 1'b0;
        #1 chk("no_btb_hit", isTakenBr_Bht, 0);
        isHit_BTB = 1'b1;

        // ---------------- saturation on PC 0x40 ----------------
        PC_EX        = 32'h40;
        isTakenBr_Ex = 1'b0;
        wr_req       = 1'b1;
        #1 chk("rw_same_idx_old", isTakenBr_Bht, 1);
        tick();
        wr_req = 1'b0;
        chk("nt1_01", isTakenBr_Bht, 0);
        train(32'h40, 1'b0); chk("nt2_00", isTakenBr_Bht, 0);
        train(32'h40, 1'b0); chk("nt3_00_sat", isTakenBr_Bht, 0);
        train(32'h40, 1'b1); chk("t1_01", isTakenBr_Bht, 0);
        train(32'h40, 1'b1); chk("t2_10", isTakenBr_Bht, 1);
        train(32'h40, 1'b1); chk("t3_11", isTakenBr_Bht, 1);
        train(32'h40, 1'b1); chk("t4_11_sat", isTakenBr_Bht, 1);
        train(32'h40, 1'b0); chk("nt4_10", isTakenBr_Bht, 1);
        train(32'h40, 1'b0); chk("nt5_01", isTakenBr_Bht, 0);
        PC_IF = 32'h44;
        #1 chk("neighbour_untouched", isTakenBr_Bht, 1);

        // ---------------- speculative shift ----------------
        PC_IF    = 32'h0;
        stall_IF = 1'b0;
        #1 chk("shift0_ghr", ghr_IF, 0);
        chk("shift0_pred", isTakenBr_Bht, 1);
        tick(); chk("shift1_ghr", ghr_IF, GS ? 32'h01 : 32'h0);
        chk("shift1_pred", isTakenBr_Bht, 1);
        tick(); chk("shift2_ghr", ghr_IF, GS ? 32'h03 : 32'h0);
        tick(); chk("shift3_ghr", ghr_IF, GS ? 32'h07 : 32'h0);
        stall_IF = 1'b1;
        tick(); chk("stall_hold", ghr_IF, GS ? 32'h07 : 32'h0);

        // ---------------- restore priority over a pending shift ----------------
        stall_IF      = 1'b0;
        mispredict_EX = 1'b1;
        ghr_EX        = 8'h78;
        isTakenBr_Ex  = 1'b0;
        tick(); chk("restore_F0", ghr_IF, GS ? 32'hF0 : 32'h0);
        ghr_EX       = 8'h0A;
        isTakenBr_Ex = 1'b1;
        tick(); chk("restore_15", ghr_IF, GS ? 32'h15 : 32'h0);
        // Restore and training in the same cycle both take effect.
        ghr_EX       = 8'h2D;
        isTakenBr_Ex = 1'b0;
        PC_EX        = 32'h80;
        wr_req       = 1'b1;
        tick();
        mispredict_EX = 1'b0;
        wr_req        = 1'b0;
        stall_IF      = 1'b1;
        ghr_EX        = '0;
        chk("restore_5A", ghr_IF, GS ? 32'h5A : 32'h0);
        // Gshare: the trained entry is 0x20^0x2D=0x0D, which is read back with PC index 0x57^0x5A.
        PC_IF = GS ? 32'h15C : 32'h80;
        #1 chk("train_with_restore", isTakenBr_Bht, 0);

        // ---------------- reset mid-run ----------------
        PC_IF = 32'h40;
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_ready", ready, 0);
        chk("midrst_ghr", ghr_IF, 0);
        chk("midrst_pred", isTakenBr_Bht, 0);
        tick();
        rst_n        = 1'b1;
        wr_req       = 1'b1;
        PC_EX        = 32'h40;
        isTakenBr_Ex = 1'b1;
        ghr_EX       = '0;
        run_sweep("reinit");
        wr_req = 1'b0;
        #1 chk("reinit_weak_taken", isTakenBr_Bht, 1);
        train(32'h40, 1'b0);
        chk("reinit_wr_ignored", isTakenBr_Bht, 0);
        chk("reinit_ghr", ghr_IF, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gshare_bht.md
# gshare_bht

Parametrised branch history table with global-history (gshare) indexing and n-bit saturating counters. Successor to the 2-bit per-PC BHT. Sits beside the BTB in IF, giving a combinational taken/not-taken prediction, and is trained from EX. Keeps a speculative global history register (GHR) with checkpoint/restore on mispredict, and clears its table after reset with a one-entry-per-cycle sweep.

## Interface
- SET_ADDR_LEN, 12: table index width; table holds 2^SET_ADDR_LEN counters.
- CNT_WIDTH, 2: saturating counter width; legal range 2..4.
- GHR_LEN, 8: global history length; legal range 1..SET_ADDR_LEN.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ready  output  1  high once the init sweep has finished.
- stall_IF  input  1  IF stage held; blocks the speculative GHR shift.
- PC_IF  input  32  fetch PC.
- isHit_BTB  input  1  BTB hit for PC_IF.
- isTakenBr_Bht  output  1  predicted taken.
- ghr_IF  output  GHR_LEN  GHR value before this fetch's shift; piped down to EX.
- wr_req  input  1  train request from EX.
- PC_EX  input  32  PC of the resolved branch.
- isTakenBr_Ex  input  1  actual branch outcome.
- ghr_EX  input  GHR_LEN  ghr_IF checkpoint carried with the branch.
- mispredict_EX  input  1  EX detected a misprediction (pipeline flush).

## Operation
- Index: idx_IF = PC_IF[SET_ADDR_LEN+1:2] XOR zero-extended GHR. idx_EX uses PC_EX and ghr_EX in the same way. The GHR is XORed into the low bits.
- Prediction: isTakenBr_Bht = ready && isHit_BTB && counter[idx_IF][CNT_WIDTH-1].
- Speculative shift: when ready && isHit_BTB && !stall_IF && !mispredict_EX, GHR <= {GHR[GHR_LEN-2:0], isTakenBr_Bht}.
- Restore: when mispredict_EX, GHR <= {ghr_EX[GHR_LEN-2:0], isTakenBr_Ex}. Restore takes priority over the speculative shift. For GHR_LEN=1, GHR <= isTakenBr_Ex.
- Training: when wr_req && ready:
  - taken: counter increments and saturates at 2^CNT_WIDTH-1.
  - not taken: counter decrements and saturates at 0.
- FSM states:
  - INIT: entered on reset. Writes counter[init_idx] = 2^(CNT_WIDTH-1) (weakly taken), one entry per cycle from 0 to 2^SET_ADDR_LEN-1. After the last entry, moves to RUN.
  - RUN: normal operation; no exit except reset.
- During INIT:
  - ready=0; prediction forced to 0.
  - wr_req, mispredict_EX and speculative shifts are ignored; the GHR stays 0.

## Timing
- Reset values: ready=0, GHR=0, ghr_IF=0, isTakenBr_Bht=0, FSM=INIT, init_idx=0.
- Reset asserted mid-operation: the above values apply immediately (asynchronously) and the sweep restarts from entry 0.
- Init takes exactly 2^SET_ADDR_LEN cycles after rst_n deasserts. ready rises on the edge that writes the last entry.
- Prediction is combinational: zero-cycle latency from PC_IF, isHit_BTB and GHR.
- Counter update is visible to reads in the cycle after the wr_req edge.
- Read and write of the same index in one cycle: the read returns the old value.
- GHR shift or restore is visible on ghr_IF and in idx_IF in the next cycle.
- wr_req and mispredict_EX in the same cycle are independent: the counter is trained and the GHR is restored.

## Configuration
- BHT_GSHARE_EN defined: behaviour as above.
- BHT_GSHARE_EN undefined:
  - GHR logic is removed; ghr_IF is tied to 0 and ghr_EX is ignored.
  - Indices are pure PC bits, giving a per-PC n-bit bimodal table.
  - stall_IF and mispredict_EX have no effect.
  - Init sweep and counters are unchanged.

## Test plan
- Reset/init (SET_ADDR_LEN=4): release rst_n -> ready=0 for 16 cycles, then 1. Every entry reads 2'b10; predict taken on a BTB hit.
- Saturation (CNT_WIDTH=2, GHR fixed 0 via stall_IF=1): 3 not-taken trains on PC 0x40 -> counter 10→01→00→00, prediction 0. Then 2 taken trains -> 01→10, prediction 1.
- Speculative shift: ready, GHR=0, isHit_BTB=1, stall_IF=0, prediction 1 for 3 cycles -> ghr_IF = 0, 1, 3, 7. With stall_IF=1 the GHR holds.
- Restore priority: GHR=8'hF0; same cycle mispredict_EX=1, ghr_EX=8'h0A, isTakenBr_Ex=1, with a speculative shift pending -> next GHR=8'h15, shift dropped.
- Reset mid-run: assert rst_n=0 in RUN with GHR=8'h5A -> ghr_IF=0 and ready=0 immediately. Full 2^SET_ADDR_LEN-cycle sweep repeats; a wr_req during the sweep is ignored.
- Macro off: rebuild without BHT_GSHARE_EN. Train PC 0x40 not-taken twice -> prediction 0 for PC 0x40 regardless of prior branch outcomes; ghr_IF stays 0.
